mem_bus_ctrl: RTL and testbench

- Bus sequencer directly downstream of the load/store byte-lane steering stage.
- Takes the word address, byte-enable mask and lane-aligned write data, and runs one transaction on a valid/ready request + rvalid response memory bus.
- Returns the raw 32-bit read word to the steering stage and signals completion, bus error or timeout so the pipeline can stall.

---
 rtl/mem_bus_ctrl.sv | 110 +++++++++++
 tb/tb_mem_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: runs one word transaction per request on a valid/ready request,
// rvalid response memory bus, with an optional cycle-count abort.
module mem_bus_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid
);

    localparam bit TO_EN = (TIMEOUT > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wr_done;
    logic             rd_accept;
    logic             rd_done;
    logic             abort;

    // Handshake: in REQ, bus_valid is high and bus_addr/bus_we/bus_wdata are
    // frozen until the cycle bus_ready is sampled high, which is the transfer.
    // A read response is a single bus_rvalid strobe, honoured only in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = REQ;
            REQ: begin
                if (wr_done)        state_nxt = IDLE;
                else if (rd_accept) state_nxt = RESP;
                else if (abort)     state_nxt = IDLE;
            end
            RESP: if (rd_done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A completing event in the expiry cycle takes priority over the abort.
    always_comb begin
        busy      = (state != IDLE);
        bus_valid = (state == REQ);
        wr_done   = (state == REQ) && bus_ready && (bus_we != 4'b0000);
        rd_accept = (state == REQ) && bus_ready && (bus_we == 4'b0000);
        rd_done   = (state == RESP) && bus_rvalid;
        abort     = TO_EN && (state != IDLE) && (cnt == CNT_LAST)
                    && !((state == REQ) && bus_ready) && !rd_done;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr  <= '0;
            bus_we    <= '0;
            bus_wdata <= '0;
        end else if (state == IDLE && req) begin
            bus_addr  <= addr;
            bus_we    <= we;
            bus_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               cnt <= '0;
        else if (!TO_EN)                         cnt <= '0;
        else if (state == IDLE || rd_accept)     cnt <= '0;
        else                                     cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= wr_done || rd_done || abort;
            err  <= abort;
            if (rd_done)
                rdata <= bus_rdata;
            else if (abort && bus_we == 4'b0000)
                rdata <= '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and randomized transactions against a timing model
// derived from per-transaction stall counts.
module tb_mem_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  we = '0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [29:0] bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rdata = '0;

    mem_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one transaction. r = cycles bus_ready is held low before the
    // accept, v = RESP cycles before bus_rvalid. Expected timing comes from
    // the stall counts and the abort budget TO.
    task automatic run_txn(input logic [3:0] t_we, input logic [29:0] t_addr,
                           input logic [31:0] t_wdata, input int r, input int v,
                           input logic [31:0] rd_word, input bit noise,
                           input string tag);
        bit          is_rd;
        bit          abort;
        int          req_last;
        int          done_cyc;
        logic [31:0] rd_exp;
        is_rd = (t_we == 4'b0000);
        if (r >= TO) begin
            abort = 1; req_last = TO; done_cyc = TO + 1;
        end else if (!is_rd) begin
            abort = 0; req_last = r + 1; done_cyc = r + 2;
        end else if (v >= TO) begin
            abort = 1; req_last = r + 1; done_cyc = r + 2 + TO;
        end else begin
            abort = 0; req_last = r + 1; done_cyc = r + 3 + v;
        end
        exp_q.push_back(!is_rd ? exp_rdata : (abort ? 32'h0 : rd_word));

        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
            req = (noise && cyc < done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            we = 4'($urandom); addr = 30'($urandom); wdata = $urandom;
            bus_ready = (cyc == r + 1);
            bus_rvalid = (cyc <= req_last) ? 1'($urandom_range(0, 1)) : (cyc == r + 2 + v);
            bus_rdata = (cyc == r + 2 + v) ? rd_word : $urandom;
            @(negedge clk);
            rd_exp = (cyc >= done_cyc) ? exp_q[0] : exp_rdata;
            n_tests++;
            if (bus_valid !== (cyc <= req_last)) begin
                n_fail++;
                $display("FAIL %s bus_valid cyc %0d: got %b want %b", tag, cyc, bus_valid, cyc <= req_last);
            end
            n_tests++;
            if (busy !== (cyc < done_cyc)) begin
                n_fail++;
                $display("FAIL %s busy cyc %0d: got %b want %b", tag, cyc, busy, cyc < done_cyc);
            end
            n_tests++;
            if (done !== (cyc == done_cyc)) begin
                n_fail++;
                $display("FAIL %s done cyc %0d: got %b want %b", tag, cyc, done, cyc == done_cyc);
            end
            n_tests++;
            if (err !== (cyc == done_cyc && abort)) begin
                n_fail++;
                $display("FAIL %s err cyc %0d: got %b want %b", tag, cyc, err, cyc == done_cyc && abort);
            end
            n_tests++;
            if (rdata !== rd_exp) begin
                n_fail++;
                $display("FAIL %s rdata cyc %0d: got %h want %h", tag, cyc, rdata, rd_exp);
            end
            if (cyc <= req_last) begin
                n_tests++;
                if (bus_addr !== t_addr || bus_we !== t_we || bus_wdata !== t_wdata) begin
                    n_fail++;
                    $display("FAIL %s bus_fields cyc %0d: got %h/%h/%h want %h/%h/%h", tag, cyc,
                             bus_addr, bus_we, bus_wdata, t_addr, t_we, t_wdata);
                end
            end
            @(posedge clk); #1;
        end
        exp_rdata = exp_q.pop_front();
        req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; we = 4'hF; addr = 30'($urandom); wdata = $urandom; bus_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if (rdata !== 32'h0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
                bus_valid !== 1'b0 || bus_addr !== 30'h0 || bus_we !== 4'h0 || bus_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rd=%h d=%b e=%b b=%b v=%b a=%h w=%h wd=%h want all 0",
                         rdata, done, err, busy, bus_valid, bus_addr, bus_we, bus_wdata);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || bus_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b valid=%b done=%b want 0/0/0", busy, bus_valid, done);
        end
        @(posedge clk); #1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_read_stalls();
        run_txn(4'b0000, 30'h0000_1234, 32'h1111_2222, 3, 2, 32'hDEAD_BEEF, 1'b0, "read_stalls");
    endtask

    task automatic test_write();
        run_txn(4'b1100, 30'h10, 32'hABCD_0000, 0, 0, 32'h0, 1'b0, "write_zero_wait");
    endtask

    task automatic test_back_to_back();
        req = 1'b1; we = 4'b0011; addr = 30'h0AA; wdata = 32'h5555_AAAA;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        req = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_addr !== 30'h0AA) begin
            n_fail++;
            $display("FAIL b2b_first_req: got valid=%b addr=%h want 1/0aa", bus_valid, bus_addr);
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; req = 1'b1; we = 4'b0000; addr = 30'h155; wdata = $urandom;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_write_done: got done=%b err=%b busy=%b want 1/0/0", done, err, busy);
        end
        @(posedge clk); #1;
        req = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_addr !== 30'h155 || bus_we !== 4'b0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_req: got valid=%b addr=%h we=%h done=%b want 1/155/0/0",
                     bus_valid, bus_addr, bus_we, done);
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hC0FF_EE01;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_resp: got valid=%b busy=%b want 0/1", bus_valid, busy);
        end
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hC0FF_EE01) begin
            n_fail++;
            $display("FAIL b2b_read_done: got done=%b err=%b rdata=%h want 1/0/c0ffee01", done, err, rdata);
        end
        @(posedge clk); #1;
        exp_rdata = 32'hC0FF_EE01;
        run_txn(4'b0000, 30'h2A, 32'h0, 2, 1, 32'h1357_9BDF, 1'b1, "req_while_busy");
    endtask

    task automatic test_timeout();
        run_txn(4'b0000, 30'h300, 32'h0, 99, 0, 32'h0, 1'b0, "timeout_read_req");
        run_txn(4'b0000, 30'h301, 32'h0, 3, 0, 32'h2468_ACE0, 1'b0, "ready_at_expiry");
        run_txn(4'b0000, 30'h302, 32'h0, 1, 2, 32'h0F0F_F0F0, 1'b0, "read_before_expiry");
        run_txn(4'b0000, 30'h303, 32'h0, 0, 99, 32'h0, 1'b0, "timeout_read_resp");
        run_txn(4'b0000, 30'h304, 32'h0, 0, 0, 32'h7777_8888, 1'b0, "read_refill");
        run_txn(4'b1111, 30'h305, 32'hFFFF_0000, 99, 0, 32'h0, 1'b0, "timeout_write");
    endtask

    task automatic test_async_reset();
        req = 1'b1; we = 4'b0000; addr = 30'h3F0; wdata = $urandom;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_req: got valid=%b busy=%b want 0/0", bus_valid, busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; addr = 30'h3F1;
        @(posedge clk); #1;
        req = 1'b0; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus_valid !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_resp: got valid=%b busy=%b rdata=%h want 0/0/0", bus_valid, busy, rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset_no_done cyc %0d: got done=%b err=%b busy=%b want 0/0/0",
                         i, done, err, busy);
            end
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b0;
        exp_rdata = 32'h0;
        run_txn(4'b0000, 30'h3F2, 32'h0, 1, 1, 32'h600D_F00D, 1'b0, "read_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] t_we;
            t_we = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_txn(t_we, 30'($urandom), $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_read_stalls();
        test_write();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
